// File: rtl/ddr3_pkg.sv
// Shared types and widths for the DDR3 write arbiter.
package ddr3_pkg;

  localparam int DDR3_ADDR_W = 27;
  localparam int DDR3_DATA_W = 256;
  localparam int DDR3_BCNT_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  // A burstcount of zero or beyond the largest legal burst is treated as one beat.
  function automatic logic [DDR3_BCNT_W-1:0] norm_burst(input logic [DDR3_BCNT_W-1:0] bc,
                                                        input int max_burst);
    if (bc == '0 || {24'd0, bc} > 32'(max_burst)) begin
      return DDR3_BCNT_W'(1);
    end
    return bc;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick: lowest requesting index strictly above
// last_grant, wrapping around. Outputs are zero when nobody requests.
module rr_select #(
  parameter int NUM_PORTS = 2,
  localparam int IDX_W = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last_grant,
  output logic [NUM_PORTS-1:0] grant_onehot,
  output logic [IDX_W-1:0]     grant_idx
);

  int         cand;
  logic [IDX_W-1:0] cand_idx;
  logic       found;

  // Walk the ports starting just after the previous owner; first requester wins.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    found        = 1'b0;
    cand         = 0;
    cand_idx     = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= NUM_PORTS) begin
        cand = cand - NUM_PORTS;
      end
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found                  = 1'b1;
        grant_idx              = cand_idx;
        grant_onehot[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr3_write_arbiter.sv
// Round-robin write arbiter feeding one DDR3 controller write port.
// A granted requester owns the controller for its whole burst; no preemption.
// Optional feature: define DDR3_ARB_STATS_EN to add per-port completed-burst
// counters on output burst_done_count.
module ddr3_write_arbiter
  import ddr3_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int MAX_BURST = 8
) (
  input  logic                                   ddr3_clk,
  input  logic                                   ddr3_clk_reset_n,
  input  logic [NUM_PORTS-1:0][DDR3_ADDR_W-1:0]  port_address,
  input  logic [NUM_PORTS-1:0][DDR3_DATA_W-1:0]  port_write_data,
  input  logic [NUM_PORTS-1:0]                   port_write,
  input  logic [NUM_PORTS-1:0][DDR3_BCNT_W-1:0]  port_burstcount,
  output logic [NUM_PORTS-1:0]                   port_waitrequest,
  output logic [DDR3_ADDR_W-1:0]                 ddr3_write_address,
  output logic [DDR3_DATA_W-1:0]                 ddr3_write_data,
  output logic                                   ddr3_write,
  output logic [DDR3_BCNT_W-1:0]                 ddr3_burstcount,
  input  logic                                   ddr3_waitrequest,
  output logic [NUM_PORTS-1:0]                   grant_onehot
`ifdef DDR3_ARB_STATS_EN
  ,
  output logic [NUM_PORTS-1:0][15:0]             burst_done_count
`endif
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
  logic [NUM_PORTS-1:0]   grant_onehot_q, grant_onehot_d;
  logic [IDX_W-1:0]       last_grant_q, last_grant_d;
  logic [DDR3_BCNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [DDR3_BCNT_W-1:0] burst_len_q, burst_len_d;

  logic [NUM_PORTS-1:0]   sel_onehot;
  logic [IDX_W-1:0]       sel_idx;
  logic                   accept;
  logic                   last_beat;
  logic [DDR3_BCNT_W-1:0] cur_len;

  rr_select #(.NUM_PORTS(NUM_PORTS)) u_rr_select (
    .req          (port_write),
    .last_grant   (last_grant_q),
    .grant_onehot (sel_onehot),
    .grant_idx    (sel_idx)
  );

  // Controller-side mux: owner's signals pass straight through, zeros when idle.
  always_comb begin
    ddr3_write         = 1'b0;
    ddr3_write_address = '0;
    ddr3_write_data    = '0;
    ddr3_burstcount    = '0;
    if (state_q == ST_BURST) begin
      ddr3_write         = port_write[grant_idx_q];
      ddr3_write_address = port_address[grant_idx_q];
      ddr3_write_data    = port_write_data[grant_idx_q];
      ddr3_burstcount    = port_burstcount[grant_idx_q];
    end
  end

  assign accept    = ddr3_write && !ddr3_waitrequest;
  // Length comes live from the requester on beat 0, from the latch afterwards.
  assign cur_len   = (beat_cnt_q == '0) ? norm_burst(port_burstcount[grant_idx_q], MAX_BURST)
                                        : burst_len_q;
  assign last_beat = accept && (beat_cnt_q == cur_len - DDR3_BCNT_W'(1));

  // Only the owner sees the controller stall; everybody else is held off.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_wait
    assign port_waitrequest[gi] = grant_onehot_q[gi] ? ddr3_waitrequest : 1'b1;
  end

  assign grant_onehot = grant_onehot_q;

  // Next-state logic: arbitrate when idle, count accepted beats while bursting.
  always_comb begin
    state_d        = state_q;
    grant_idx_d    = grant_idx_q;
    grant_onehot_d = grant_onehot_q;
    last_grant_d   = last_grant_q;
    beat_cnt_d     = beat_cnt_q;
    burst_len_d    = burst_len_q;
    case (state_q)
      ST_IDLE: begin
        if (|port_write) begin
          state_d        = ST_BURST;
          grant_idx_d    = sel_idx;
          grant_onehot_d = sel_onehot;
          beat_cnt_d     = '0;
        end
      end
      ST_BURST: begin
        if (accept) begin
          if (beat_cnt_q == '0) begin
            burst_len_d = cur_len;
          end
          if (last_beat) begin
            state_d        = ST_IDLE;
            grant_onehot_d = '0;
            last_grant_d   = grant_idx_q;
            beat_cnt_d     = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + DDR3_BCNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any burst and makes port 0 the first winner.
  always_ff @(posedge ddr3_clk or negedge ddr3_clk_reset_n) begin
    if (!ddr3_clk_reset_n) begin
      state_q        <= ST_IDLE;
      grant_idx_q    <= '0;
      grant_onehot_q <= '0;
      last_grant_q   <= IDX_W'(NUM_PORTS - 1);
      beat_cnt_q     <= '0;
      burst_len_q    <= '0;
    end else begin
      state_q        <= state_d;
      grant_idx_q    <= grant_idx_d;
      grant_onehot_q <= grant_onehot_d;
      last_grant_q   <= last_grant_d;
      beat_cnt_q     <= beat_cnt_d;
      burst_len_q    <= burst_len_d;
    end
  end

`ifdef DDR3_ARB_STATS_EN
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_stats
    logic [15:0] done_cnt_q, done_cnt_d;

    // Bump this port's counter on the final accepted beat of its burst; wraps.
    always_comb begin
      done_cnt_d = done_cnt_q;
      if (last_beat && grant_onehot_q[gi]) begin
        done_cnt_d = done_cnt_q + 16'd1;
      end
    end

    // Per-port completed-burst counter register.
    always_ff @(posedge ddr3_clk or negedge ddr3_clk_reset_n) begin
      if (!ddr3_clk_reset_n) begin
        done_cnt_q <= '0;
      end else begin
        done_cnt_q <= done_cnt_d;
      end
    end

    assign burst_done_count[gi] = done_cnt_q;
  end
`endif

endmodule

// File: tb/tb_ddr3_write_arbiter.sv
// Self-checking bench for ddr3_write_arbiter (two ports, default burst limit).
// Directed scenarios pin literal expectations; a random phase is checked every
// cycle against a transaction-level model. Build with DDR3_ARB_STATS_EN to
// also check the burst counters.
module tb_ddr3_write_arbiter;
  import ddr3_pkg::*;

  localparam int NP = 2;
  localparam int MB = 8;

  logic                           clk = 1'b0;
  logic                           rst_n = 1'b0;
  logic [NP-1:0][DDR3_ADDR_W-1:0] port_address;
  logic [NP-1:0][DDR3_DATA_W-1:0] port_write_data;
  logic [NP-1:0]                  port_write;
  logic [NP-1:0][DDR3_BCNT_W-1:0] port_burstcount;
  logic [NP-1:0]                  port_waitrequest;
  logic [DDR3_ADDR_W-1:0]         ddr3_write_address;
  logic [DDR3_DATA_W-1:0]         ddr3_write_data;
  logic                           ddr3_write;
  logic [DDR3_BCNT_W-1:0]         ddr3_burstcount;
  logic                           ddr3_waitrequest;
  logic [NP-1:0]                  grant_onehot;
`ifdef DDR3_ARB_STATS_EN
  logic [NP-1:0][15:0]            burst_done_count;
`endif

  int checks = 0;
  int errors = 0;

  // Model: who owns the controller, how many beats taken, round-robin pointer.
  int m_owner = -1;
  int m_cnt   = 0;
  int m_len   = 0;
  int m_last  = NP - 1;
  int m_done [NP];

  ddr3_write_arbiter #(.NUM_PORTS(NP), .MAX_BURST(MB)) dut (
    .ddr3_clk           (clk),
    .ddr3_clk_reset_n   (rst_n),
    .port_address       (port_address),
    .port_write_data    (port_write_data),
    .port_write         (port_write),
    .port_burstcount    (port_burstcount),
    .port_waitrequest   (port_waitrequest),
    .ddr3_write_address (ddr3_write_address),
    .ddr3_write_data    (ddr3_write_data),
    .ddr3_write         (ddr3_write),
    .ddr3_burstcount    (ddr3_burstcount),
    .ddr3_waitrequest   (ddr3_waitrequest),
    .grant_onehot       (grant_onehot)
`ifdef DDR3_ARB_STATS_EN
    ,
    .burst_done_count   (burst_done_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic int norm(input int bc);
    return (bc == 0 || bc > MB) ? 1 : bc;
  endfunction

  function automatic logic [255:0] rand_data();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model update on every clock edge (and immediately on reset).
  initial begin
    foreach (m_done[i]) m_done[i] = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_owner = -1; m_cnt = 0; m_len = 0; m_last = NP - 1;
        foreach (m_done[i]) m_done[i] = 0;
      end else if (m_owner < 0) begin
        for (int k = 1; k <= NP; k++) begin
          if (m_owner < 0 && port_write[(m_last + k) % NP]) begin
            m_owner = (m_last + k) % NP;
            m_cnt   = 0;
          end
        end
      end else if (port_write[m_owner] && !ddr3_waitrequest) begin
        if (m_cnt == 0) m_len = norm(int'(port_burstcount[m_owner]));
        if (m_cnt == m_len - 1) begin
          m_done[m_owner] = (m_done[m_owner] + 1) % 65536;
          m_last  = m_owner;
          m_owner = -1;
          m_cnt   = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  task automatic compare_all();
    logic [NP-1:0]          e_wait, e_grant;
    logic                   e_w;
    logic [DDR3_ADDR_W-1:0] e_a;
    logic [DDR3_DATA_W-1:0] e_d;
    logic [DDR3_BCNT_W-1:0] e_bc;
    e_wait = '1; e_grant = '0; e_w = 1'b0; e_a = '0; e_d = '0; e_bc = '0;
    if (m_owner >= 0) begin
      e_w  = port_write[m_owner];
      e_a  = port_address[m_owner];
      e_d  = port_write_data[m_owner];
      e_bc = port_burstcount[m_owner];
      e_wait[m_owner]  = ddr3_waitrequest;
      e_grant[m_owner] = 1'b1;
    end
    chk("ddr3_write", 256'(ddr3_write), 256'(e_w));
    chk("ddr3_addr", 256'(ddr3_write_address), 256'(e_a));
    chk("ddr3_data", ddr3_write_data, e_d);
    chk("ddr3_bcnt", 256'(ddr3_burstcount), 256'(e_bc));
    chk("port_waitreq", 256'(port_waitrequest), 256'(e_wait));
    chk("grant_onehot", 256'(grant_onehot), 256'(e_grant));
`ifdef DDR3_ARB_STATS_EN
    for (int i = 0; i < NP; i++) chk("burst_done_count", 256'(burst_done_count[i]), 256'(m_done[i]));
`endif
  endtask

  // Per-cycle comparison, well clear of the clock edge and of input changes.
  initial begin
    forever begin
      @(posedge clk);
      #4;
      compare_all();
    end
  end

  task automatic idle_inputs();
    port_write = '0; port_burstcount = '0; port_address = '0; port_write_data = '0;
    ddr3_waitrequest = 1'b0;
  endtask

  // Leaves the caller at posedge+1 with reset released.
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_ddr3_write", 256'(ddr3_write), 256'(0));
    chk("rst_waitreq", 256'(port_waitrequest), 256'(2'b11));
    chk("rst_grant", 256'(grant_onehot), 256'(0));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Drive one burst from port p. Called and returns at posedge+1, except when
  // abort_at is reached, where it returns at posedge+3 mid-burst.
  task automatic burst(input int p, input int bc, input int st_a, input int st_b,
                       input int abort_at, input int raise_at,
                       output int beats, output int gcyc, output int first_g,
                       output int oth_low, output int stalls);
    int len;
    bit sa, sb, aborted;
    len = norm(bc);
    beats = 0; gcyc = 0; first_g = -1; oth_low = 0; stalls = 0;
    sa = 0; sb = 0; aborted = 0;
    port_write[p] = 1'b1;
    port_burstcount[p] = 8'(bc);
    port_address[p] = 27'($urandom);
    port_write_data[p] = rand_data();
    ddr3_waitrequest = 1'b0;
    for (int c = 0; c < 60; c++) begin
      #2;
      if (grant_onehot[p]) begin
        gcyc++;
        if (first_g < 0) first_g = c;
        if (port_waitrequest[p]) stalls++;
        if (ddr3_write && !ddr3_waitrequest) beats++;
      end
      for (int q = 0; q < NP; q++) if (q != p && !port_waitrequest[q]) oth_low++;
      if (beats == abort_at) begin aborted = 1; break; end
      if (beats >= len) break;
      @(posedge clk); #1;
      if (c + 1 == raise_at) begin
        port_write[(p + 1) % NP] = 1'b1;
        port_burstcount[(p + 1) % NP] = 8'd4;
      end
      port_address[p] = 27'($urandom);
      port_write_data[p] = rand_data();
      if (beats > 0) port_burstcount[p] = 8'($urandom_range(0, 255));
      ddr3_waitrequest = 1'b0;
      if (grant_onehot[p] && beats == st_a && !sa) begin ddr3_waitrequest = 1'b1; sa = 1; end
      if (grant_onehot[p] && beats == st_b && !sb) begin ddr3_waitrequest = 1'b1; sb = 1; end
    end
    if (!aborted) begin
      @(posedge clk); #1;
      ddr3_waitrequest = 1'b0;
      port_write[p] = 1'b0;
    end
  endtask

  int b, g, f, o, s;
  int seq_exp [8] = '{0, 1, 1, 0, 2, 2, 0, 1};

  initial begin
    idle_inputs();
    do_reset();

    // Port 0 alone, 8-beat burst, no controller stall.
    burst(0, 8, -1, -1, -1, -1, b, g, f, o, s);
    $display("txn p0 burst8: beats=%0d granted_cycles=%0d first_grant=%0d", b, g, f);
    chk("p0_beats", 256'(b), 256'(8));
    chk("p0_gcycles", 256'(g), 256'(8));
    chk("p0_grant_latency", 256'(f), 256'(1));
    chk("p1_held_off", 256'(o), 256'(0));
    #2;
    chk("idle_after_burst", 256'({ddr3_write, grant_onehot}), 256'(0));
    @(posedge clk); #1;

    // Controller stalls on beats 3 and 4.
    burst(1, 8, 2, 3, -1, -1, b, g, f, o, s);
    $display("txn p1 burst8 stalled: beats=%0d granted_cycles=%0d stalls=%0d", b, g, s);
    chk("stall_beats", 256'(b), 256'(8));
    chk("stall_gcycles", 256'(g), 256'(10));
    chk("stall_count", 256'(s), 256'(2));

    // Port 1 asks mid-burst; must wait, then win one cycle after the last beat.
    burst(0, 8, -1, -1, -1, 3, b, g, f, o, s);
    $display("txn p0 burst8 with p1 pending: beats=%0d granted_cycles=%0d", b, g);
    chk("nopreempt_gcycles", 256'(g), 256'(8));
    chk("nopreempt_held_off", 256'(o), 256'(0));
    burst(1, 4, -1, -1, -1, -1, b, g, f, o, s);
    $display("txn p1 burst4 after wait: beats=%0d first_grant=%0d", b, f);
    chk("p1_after_latency", 256'(f), 256'(1));
    chk("p1_after_beats", 256'(b), 256'(4));

    // Degenerate burstcounts are one beat.
    burst(0, 0, -1, -1, -1, -1, b, g, f, o, s);
    $display("txn p0 burstcount0: beats=%0d granted_cycles=%0d", b, g);
    chk("bc0_gcycles", 256'(g), 256'(1));
    burst(1, 12, -1, -1, -1, -1, b, g, f, o, s);
    $display("txn p1 burstcount12: beats=%0d granted_cycles=%0d", b, g);
    chk("bc_over_gcycles", 256'(g), 256'(1));

    // Reset during beat 5 abandons the burst; next burst counts from zero.
    burst(0, 8, -1, -1, 5, -1, b, g, f, o, s);
    rst_n = 1'b0;
    #1;
    $display("txn reset mid-burst at beat %0d: ddr3_write=%0b grant=%0b", b, ddr3_write, grant_onehot);
    chk("midrst_write", 256'(ddr3_write), 256'(0));
    chk("midrst_grant", 256'(grant_onehot), 256'(0));
    chk("midrst_waitreq", 256'(port_waitrequest), 256'(2'b11));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    burst(0, 8, -1, -1, -1, -1, b, g, f, o, s);
    $display("txn p0 burst8 after reset: beats=%0d granted_cycles=%0d", b, g);
    chk("rerun_gcycles", 256'(g), 256'(8));
    chk("rerun_beats", 256'(b), 256'(8));

    // Both ports from reset: 0, then 1, then 0 again.
    idle_inputs();
    do_reset();
    port_write = 2'b11;
    port_burstcount[0] = 8'd2;
    port_burstcount[1] = 8'd2;
    for (int c = 0; c < 8; c++) begin
      #2;
      $display("txn both-request cycle %0d: grant=%0b", c, grant_onehot);
      chk("rr_sequence", 256'(grant_onehot), 256'(seq_exp[c]));
      @(posedge clk); #1;
    end

`ifdef DDR3_ARB_STATS_EN
    idle_inputs();
    do_reset();
    for (int i = 0; i < 5; i++) burst(i % 2, 2, -1, -1, -1, -1, b, g, f, o, s);
    $display("txn stats: p0=%0d p1=%0d", burst_done_count[0], burst_done_count[1]);
    chk("stats_p0", 256'(burst_done_count[0]), 256'(3));
    chk("stats_p1", 256'(burst_done_count[1]), 256'(2));
`endif

    // Random traffic against the model.
    idle_inputs();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < NP; p++) begin
        port_write[p] = ($urandom % 3) != 0;
        port_burstcount[p] = 8'($urandom_range(0, 10));
        port_address[p] = 27'($urandom);
        port_write_data[p] = rand_data();
      end
      ddr3_waitrequest = ($urandom % 4) == 0;
      rst_n = ($urandom % 400) != 0;
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    $display("txn random phase: 3000 cycles");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
